// File: rtl/mult_seq_n.sv
// Sequential W-bit shift-and-add multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN to add the sgn port and two's-complement mode.
module mult_seq_n #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   datoA,
  input  logic [W-1:0]   datoB,
`ifdef MULT_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  a;
  logic [W-1:0]  sumh;
  logic [W-1:0]  suml;
  logic [CW-1:0] cnt;
  logic          last;
  logic [W:0]    ext_h;
  logic [W:0]    ext_a;
  logic [W:0]    sum;

  assign last = (cnt == CW'(W - 1));

`ifdef MULT_SIGNED_EN
  logic sg;

  // {C,S} is W+1 bits so the carry (unsigned) or sign (signed) feeds the shift
  always_comb begin
    ext_h = {sg & sumh[W-1], sumh};
    ext_a = {sg & a[W-1], a};
    sum   = ext_h;
    if (suml[0]) begin
      if (sg && last) sum = ext_h - ext_a;
      else            sum = ext_h + ext_a;
    end
  end
`else
  always_comb begin
    ext_h = {1'b0, sumh};
    ext_a = {1'b0, a};
    sum   = ext_h;
    if (suml[0]) sum = ext_h + ext_a;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a     <= '0;
      sumh  <= '0;
      suml  <= '0;
      cnt   <= '0;
`ifdef MULT_SIGNED_EN
      sg    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a     <= datoA;
            suml  <= datoB;
            sumh  <= '0;
            cnt   <= '0;
`ifdef MULT_SIGNED_EN
            sg    <= sgn;
`endif
            state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          {sumh, suml} <= {sum, suml[W-1:1]};
          cnt          <= cnt + 1'b1;
          if (last) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_LOAD) || (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = {sumh, suml};

endmodule

// File: tb/tb_mult_seq_n.sv
// Directed bench for mult_seq_n: W=4 and W=8 instances on one clock.
// Signed vectors run only when MULT_SIGNED_EN is defined.
module tb_mult_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  res4;
  logic [15:0] res8;
`ifdef MULT_SIGNED_EN
  logic        sgn4, sgn8;
`endif

  int n_vec = 0;
  int n_bad = 0;

  mult_seq_n #(.W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .datoA(a4), .datoB(b4),
`ifdef MULT_SIGNED_EN
    .sgn(sgn4),
`endif
    .busy(busy4), .done(done4), .result(res4)
  );

  mult_seq_n #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .datoA(a8), .datoB(b8),
`ifdef MULT_SIGNED_EN
    .sgn(sgn8),
`endif
    .busy(busy8), .done(done8), .result(res8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit wide, input logic [7:0] a,
                     input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string tag);
    int   lat;
    logic dn;
    if (wide) begin
      a8 = a; b8 = b; start8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
    end
`ifdef MULT_SIGNED_EN
    sgn4 = s;
    sgn8 = s;
`else
    if (s) $display("note: %s wants signed mode, unsigned build", tag);
`endif
    tick;
    start4 = 1'b0;
    start8 = 1'b0;
    chk({tag, " busy"}, wide ? busy8 : busy4, 1);
    lat = 0;
    dn  = 1'b0;
    while (!dn && lat < 40) begin
      tick;
      lat++;
      dn = wide ? done8 : done4;
    end
    chk({tag, " latency"}, lat, wide ? 9 : 5);
    chk({tag, " busy@done"}, wide ? busy8 : busy4, 0);
    chk({tag, " result"}, wide ? res8 : {8'h00, res4}, exp);
    tick;
  endtask

  logic [3:0] ha [3];
  logic [3:0] hb [3];
  logic [7:0] he [3];

  initial begin
    int   i, cyc, last_done;
    logic seen;

    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
`ifdef MULT_SIGNED_EN
    sgn4 = 1'b0; sgn8 = 1'b0;
`endif
    tick;
    tick;
    chk("reset busy", busy4, 0);
    chk("reset done", done4, 0);
    chk("reset result", res4, 8'h00);
    rst = 1'b0;
    tick;

    run(0, 8'd13, 8'd11, 1'b0, 16'h008F, "13x11");
    run(0, 8'd15, 8'd15, 1'b0, 16'h00E1, "15x15");
    run(0, 8'd0,  8'd9,  1'b0, 16'h0000, "0x9");

    // start held high, operands scrambled while busy
    ha = '{4'd3, 4'd15, 4'd9};
    hb = '{4'd5, 4'd14, 4'd12};
    he = '{8'h0F, 8'hD2, 8'h6C};
    i = 0; cyc = 0; last_done = 0;
    a4 = ha[0]; b4 = hb[0]; start4 = 1'b1;
    while (i < 3 && cyc < 60) begin
      tick;
      cyc++;
      if (done4) begin
        chk("hold result", res4, he[i]);
        if (i > 0) chk("hold period", cyc - last_done, 7);
        last_done = cyc;
        i++;
        if (i < 3) begin
          a4 = ha[i]; b4 = hb[i];
        end
      end else if (busy4) begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
      end
    end
    start4 = 1'b0;
    chk("hold count", i, 3);
    tick;

    // reset during the second RUN cycle
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("abort busy", busy4, 0);
    chk("abort done", done4, 0);
    chk("abort result", res4, 8'h00);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick;
      if (done4) seen = 1'b1;
    end
    chk("abort no done", seen, 0);

    // rst and start on the same edge
    rst = 1'b1; start4 = 1'b1;
    tick;
    chk("rst beats start", busy4, 0);
    rst = 1'b0; start4 = 1'b0;
    tick;

    run(0, 8'd7, 8'd6, 1'b0, 16'h002A, "7x6");

`ifdef MULT_SIGNED_EN
    run(0, 8'h0D, 8'h05, 1'b1, 16'h00F1, "s -3x5");
    run(0, 8'h08, 8'h08, 1'b1, 16'h0040, "s -8x-8");
    run(0, 8'h07, 8'h0F, 1'b1, 16'h00F9, "s 7x-1");
    run(0, 8'd13, 8'd11, 1'b0, 16'h008F, "u 13x11");
`endif

    run(1, 8'd255, 8'd255, 1'b0, 16'hFE01, "w8 255x255");
    run(1, 8'd200, 8'd3,   1'b0, 16'h0258, "w8 200x3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
